// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the two-requester data-memory arbiter.
package dmem_arb_pkg;

  typedef enum logic {
    REQ_CORE = 1'b0,
    REQ_DBG  = 1'b1
  } req_id_e;

  localparam int ARB_RR    = 0;
  localparam int ARB_FIXED = 1;

  localparam int MEM_ADDR_W = 8;
  localparam int MEM_DATA_W = 32;

  // Default-width view of one memory access request.
  typedef struct packed {
    logic                  we_re;
    logic [3:0]            mask;
    logic [MEM_ADDR_W-1:0] addr;
    logic [MEM_DATA_W-1:0] wdata;
  } mem_req_t;

  function automatic req_id_e other_id(input req_id_e id);
    return (id == REQ_CORE) ? REQ_DBG : REQ_CORE;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-input combinational grant logic with a one-bit round-robin priority pointer.
module rr_arb2
  import dmem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       mode,
  output logic [1:0] gnt,
  output logic       win_id
);

  req_id_e prio_q;
  req_id_e prio_d;
  req_id_e win;

  always_comb begin
    win    = REQ_CORE;
    gnt    = 2'b00;
    prio_d = prio_q;
    case (req)
      2'b10:   win = REQ_DBG;
      2'b11:   win = mode ? REQ_CORE : prio_q;
      default: win = REQ_CORE;
    endcase
    if (|req) begin
      gnt = (win == REQ_DBG) ? 2'b10 : 2'b01;
      // Fixed-priority mode never consults the pointer, so leave it alone.
      if (!mode) prio_d = other_id(win);
    end
  end

  assign win_id = win;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) prio_q <= REQ_CORE;
    else      prio_q <= prio_d;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the LSU (requester 0) and the
// debug/DMA port (requester 1); routes one-cycle-latency read data back.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ARB_MODE = ARB_RR,
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 32
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              r0_req,
  input  logic              r0_we_re,
  input  logic [3:0]        r0_mask,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_gnt,
  output logic              r0_rvalid,
  output logic [DATA_W-1:0] r0_rdata,

  input  logic              r1_req,
  input  logic              r1_we_re,
  input  logic [3:0]        r1_mask,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_gnt,
  output logic              r1_rvalid,
  output logic [DATA_W-1:0] r1_rdata,

  output logic              mem_request,
  output logic              mem_we_re,
  output logic              mem_load,
  output logic [3:0]        mem_mask,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic              mem_valid,
  input  logic [DATA_W-1:0] mem_data_out
);

  typedef struct packed {
    logic              we_re;
    logic [3:0]        mask;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  localparam logic FIXED_MODE = (ARB_MODE == ARB_FIXED);

  logic [1:0] req_vec;
  logic [1:0] gnt_vec;
  logic       win_id;
  req_t       r0_f, r1_f, win_f;

  logic rd_pend_q,  rd_pend_d;
  logic rd_owner_q, rd_owner_d;

  // Requests are masked during reset so no grant or memory strobe can leak out.
  assign req_vec = {r1_req, r0_req} & {2{rst}};

  rr_arb2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    (req_vec),
    .mode   (FIXED_MODE),
    .gnt    (gnt_vec),
    .win_id (win_id)
  );

  assign r0_gnt = gnt_vec[0];
  assign r1_gnt = gnt_vec[1];

  always_comb begin
    r0_f        = '{we_re: r0_we_re, mask: r0_mask, addr: r0_addr, wdata: r0_wdata};
    r1_f        = '{we_re: r1_we_re, mask: r1_mask, addr: r1_addr, wdata: r1_wdata};
    win_f       = win_id ? r1_f : r0_f;
    mem_request = |gnt_vec;
    mem_we_re   = 1'b0;
    mem_mask    = '0;
    mem_address = '0;
    mem_data_in = '0;
    if (mem_request) begin
      mem_we_re   = win_f.we_re;
      mem_mask    = win_f.mask;
      mem_address = win_f.addr;
      mem_data_in = win_f.wdata;
    end
    mem_load   = mem_request & ~win_f.we_re;
    rd_pend_d  = mem_load;
    rd_owner_d = win_id;
  end

  // Pipeline register, not a handshake: a new read may issue every cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_pend_q  <= 1'b0;
      rd_owner_q <= 1'b0;
    end else begin
      rd_pend_q  <= rd_pend_d;
      rd_owner_q <= rd_owner_d;
    end
  end

  assign r0_rvalid = mem_valid & rd_pend_q & (rd_owner_q == REQ_CORE);
  assign r1_rvalid = mem_valid & rd_pend_q & (rd_owner_q == REQ_DBG);
  assign r0_rdata  = r0_rvalid ? mem_data_out : '0;
  assign r1_rdata  = r1_rvalid ? mem_data_out : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomised scoreboard bench for dmem_arbiter: one instance per arbitration mode,
// each with its own memory model and a high-level reference of grants and memory contents.
module tb_dmem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        load_en;

  logic        r_req   [2][2];
  logic        r_we    [2][2];
  logic [3:0]  r_mask  [2][2];
  logic [7:0]  r_addr  [2][2];
  logic [31:0] r_wdata [2][2];
  logic        gnt     [2][2];
  logic        rvalid  [2][2];
  logic [31:0] rdata   [2][2];

  logic        m_req  [2];
  logic        m_we   [2];
  logic        m_load [2];
  logic [3:0]  m_mask [2];
  logic [7:0]  m_addr [2];
  logic [31:0] m_din  [2];
  logic        m_valid[2];
  logic [31:0] m_dout [2];

  logic [31:0] mem_arr [2][256];

  int checks   = 0;
  int failures = 0;

  // Reference state: priority pointer, expected read data per requester, memory image.
  int          prio    [2];
  bit          exp_rv  [2][2];
  bit          last_gnt[2][2];
  logic [31:0] ref_mem [2][256];
  logic [31:0] exp_q   [2][2][$];

  for (genvar m = 0; m < 2; m++) begin : g_dut
    dmem_arbiter #(.ARB_MODE(m), .ADDR_W(8), .DATA_W(32)) u_dut (
      .clk          (clk),
      .rst          (rst),
      .r0_req       (r_req[m][0]),
      .r0_we_re     (r_we[m][0]),
      .r0_mask      (r_mask[m][0]),
      .r0_addr      (r_addr[m][0]),
      .r0_wdata     (r_wdata[m][0]),
      .r0_gnt       (gnt[m][0]),
      .r0_rvalid    (rvalid[m][0]),
      .r0_rdata     (rdata[m][0]),
      .r1_req       (r_req[m][1]),
      .r1_we_re     (r_we[m][1]),
      .r1_mask      (r_mask[m][1]),
      .r1_addr      (r_addr[m][1]),
      .r1_wdata     (r_wdata[m][1]),
      .r1_gnt       (gnt[m][1]),
      .r1_rvalid    (rvalid[m][1]),
      .r1_rdata     (rdata[m][1]),
      .mem_request  (m_req[m]),
      .mem_we_re    (m_we[m]),
      .mem_load     (m_load[m]),
      .mem_mask     (m_mask[m]),
      .mem_address  (m_addr[m]),
      .mem_data_in  (m_din[m]),
      .mem_valid    (m_valid[m]),
      .mem_data_out (m_dout[m])
    );
  end

  function automatic logic [31:0] init_val(input int a);
    logic [7:0] b;
    b = a[7:0];
    if (a == 16) return 32'hDEADBEEF;
    return {b, ~b, 8'h5A, b + 8'd17};
  endfunction

  task automatic chk(input string name, input int m, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s inst%0d: got %h expected %h at %0t", name, m, act, exp, $time);
    end
  endtask

  // Memory wrapper model: byte-masked writes, reads return one cycle later,
  // plus occasional stray mem_valid pulses and junk data when not reading.
  always @(posedge clk) begin
    for (int m = 0; m < 2; m++) begin
      if (load_en) begin
        for (int a = 0; a < 256; a++) mem_arr[m][a] <= init_val(a);
      end else if (m_req[m] && m_we[m]) begin
        for (int b = 0; b < 4; b++)
          if (m_mask[m][b]) mem_arr[m][m_addr[m]][8*b +: 8] <= m_din[m][8*b +: 8];
      end
      m_valid[m] <= m_load[m] | ($urandom_range(0, 5) == 0);
      m_dout[m]  <= m_load[m] ? mem_arr[m][m_addr[m]] : $urandom;
    end
  end

  // Response monitor: every rvalid must match the oldest expected read of that requester.
  always @(negedge clk) begin
    for (int m = 0; m < 2; m++) begin
      for (int id = 0; id < 2; id++) begin
        if (rvalid[m][id] === 1'b1) begin
          checks++;
          if (exp_q[m][id].size() == 0) begin
            failures++;
            $display("FAIL rvalid_unexpected inst%0d r%0d: got rvalid=1 data %h expected no response",
                     m, id, rdata[m][id]);
          end else begin
            logic [31:0] e;
            e = exp_q[m][id].pop_front();
            checks--;
            chk($sformatf("rdata_r%0d", id), m, rdata[m][id], e);
          end
        end else begin
          chk($sformatf("rdata_idle_r%0d", id), m, rdata[m][id], 32'h0);
        end
      end
    end
  end

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      prio[m] = 0;
      for (int id = 0; id < 2; id++) begin
        exp_rv[m][id] = 1'b0;
        exp_q[m][id].delete();
      end
    end
  endtask

  task automatic check_cycle();
    for (int m = 0; m < 2; m++)
      for (int id = 0; id < 2; id++) last_gnt[m][id] = 1'b0;
    if (!rst) begin
      for (int m = 0; m < 2; m++) begin
        chk("rst_r0_gnt", m, 32'(gnt[m][0]), 32'h0);
        chk("rst_r1_gnt", m, 32'(gnt[m][1]), 32'h0);
        chk("rst_r0_rvalid", m, 32'(rvalid[m][0]), 32'h0);
        chk("rst_r1_rvalid", m, 32'(rvalid[m][1]), 32'h0);
        chk("rst_mem_request", m, 32'(m_req[m]), 32'h0);
        chk("rst_mem_we_re", m, 32'(m_we[m]), 32'h0);
        chk("rst_mem_load", m, 32'(m_load[m]), 32'h0);
        chk("rst_mem_mask", m, 32'(m_mask[m]), 32'h0);
        chk("rst_mem_address", m, 32'(m_addr[m]), 32'h0);
        chk("rst_mem_data_in", m, m_din[m], 32'h0);
      end
      model_reset();
      return;
    end
    for (int m = 0; m < 2; m++) begin
      bit q0, q1, any, we;
      int w;
      q0  = r_req[m][0];
      q1  = r_req[m][1];
      any = q0 | q1;
      if (q0 && q1) w = (m == 1) ? 0 : prio[m];
      else          w = q1 ? 1 : 0;
      we = r_we[m][w];
      chk("r0_gnt", m, 32'(gnt[m][0]), 32'(any && w == 0));
      chk("r1_gnt", m, 32'(gnt[m][1]), 32'(any && w == 1));
      chk("mem_request", m, 32'(m_req[m]), 32'(any));
      chk("mem_we_re", m, 32'(m_we[m]), any ? 32'(we) : 32'h0);
      chk("mem_load", m, 32'(m_load[m]), 32'(any && !we));
      chk("mem_mask", m, 32'(m_mask[m]), any ? 32'(r_mask[m][w]) : 32'h0);
      chk("mem_address", m, 32'(m_addr[m]), any ? 32'(r_addr[m][w]) : 32'h0);
      chk("mem_data_in", m, m_din[m], any ? r_wdata[m][w] : 32'h0);
      for (int id = 0; id < 2; id++) begin
        chk($sformatf("rvalid_timing_r%0d", id), m, 32'(rvalid[m][id]), 32'(exp_rv[m][id]));
        exp_rv[m][id] = 1'b0;
      end
      if (any) begin
        last_gnt[m][w] = 1'b1;
        if (m == 0) prio[m] = 1 - w;
        if (!we) begin
          exp_q[m][w].push_back(ref_mem[m][r_addr[m][w]]);
          exp_rv[m][w] = 1'b1;
        end else begin
          for (int b = 0; b < 4; b++)
            if (r_mask[m][w][b]) ref_mem[m][r_addr[m][w]][8*b +: 8] = r_wdata[m][w][8*b +: 8];
        end
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int id, input bit req, input bit we, input logic [3:0] mask,
                         input logic [7:0] addr, input logic [31:0] wdata);
    for (int m = 0; m < 2; m++) begin
      r_req[m][id]   = req;
      r_we[m][id]    = we;
      r_mask[m][id]  = mask;
      r_addr[m][id]  = addr;
      r_wdata[m][id] = wdata;
    end
  endtask

  task automatic randomize_req(input int m, input int id);
    r_req[m][id]   = ($urandom_range(0, 3) != 0);
    r_we[m][id]    = $urandom_range(0, 1) == 1;
    r_mask[m][id]  = 4'($urandom_range(0, 15));
    r_addr[m][id]  = 8'($urandom_range(0, 15));
    r_wdata[m][id] = $urandom;
  endtask

  initial begin
    rst     = 1'b0;
    load_en = 1'b1;
    set_req(0, 1'b1, 1'b0, 4'hF, 8'h00, 32'h0);
    set_req(1, 1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
    for (int m = 0; m < 2; m++)
      for (int a = 0; a < 256; a++) ref_mem[m][a] = init_val(a);
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    load_en = 1'b0;
    step();
    step();

    // Release with r0 still requesting: lone grant, pointer moves to r1.
    rst = 1'b1;
    step();
    set_req(0, 1'b1, 1'b0, 4'hF, 8'h20, 32'h0);
    set_req(1, 1'b1, 1'b0, 4'hF, 8'h21, 32'h0);
    step();
    set_req(0, 1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
    set_req(1, 1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
    step();

    // Single read of the preloaded word.
    set_req(0, 1'b1, 1'b0, 4'hF, 8'h10, 32'h0);
    step();
    set_req(0, 1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
    step();
    step();

    // Contention: r0 writes, r1 reads, then r0 drops out.
    set_req(0, 1'b1, 1'b1, 4'hF, 8'h04, 32'hA5A5A5A5);
    set_req(1, 1'b1, 1'b0, 4'hF, 8'h08, 32'h0);
    repeat (5) step();
    set_req(0, 1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
    step();
    set_req(1, 1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
    step();

    // Back-to-back reads from different requesters.
    set_req(1, 1'b1, 1'b0, 4'hF, 8'h01, 32'h0);
    step();
    set_req(1, 1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
    set_req(0, 1'b1, 1'b0, 4'hF, 8'h02, 32'h0);
    step();
    set_req(0, 1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
    step();
    step();

    // Reset pulse while a read is in flight: its data must be dropped.
    set_req(0, 1'b1, 1'b0, 4'hF, 8'h10, 32'h0);
    step();
    set_req(0, 1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
    rst = 1'b0;
    #2;
    rst = 1'b1;
    model_reset();
    step();
    set_req(1, 1'b1, 1'b0, 4'hF, 8'h03, 32'h0);
    step();
    set_req(1, 1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
    step();

    // Random traffic; a requester holds its fields until the model says it was granted.
    repeat (3000) begin
      for (int m = 0; m < 2; m++)
        for (int id = 0; id < 2; id++)
          if (!r_req[m][id] || last_gnt[m][id]) randomize_req(m, id);
      step();
    end

    set_req(0, 1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
    set_req(1, 1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
    repeat (3) step();
    for (int m = 0; m < 2; m++)
      for (int id = 0; id < 2; id++)
        chk($sformatf("outstanding_reads_r%0d", id), m, 32'(exp_q[m][id].size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter that shares the single-port data memory wrapper between requester 0 (core load/store unit) and requester 1 (debug/DMA port).
- Grants at most one access per cycle and drives the memory's request, we_re, load, mask, address and data_in.
- Routes each read response, which returns one cycle after issue, back to the requester that issued it.
- Sits between the LSU/debug logic and the data memory wrapper.

Parameters:
- ARB_MODE, 0, 0 = round-robin between requesters; 1 = fixed priority, requester 0 always wins.
- ADDR_W, 8, memory word-address width.
- DATA_W, 32, data width.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- r0_req  input  1  requester 0 access request; held stable with its fields until r0_gnt.
- r0_we_re  input  1  1 = write, 0 = read.
- r0_mask  input  4  byte-enable mask.
- r0_addr  input  ADDR_W  address.
- r0_wdata  input  DATA_W  write data.
- r0_gnt  output  1  access accepted this cycle.
- r0_rvalid  output  1  read data valid for requester 0.
- r0_rdata  output  DATA_W  read data.
- r1_req, r1_we_re, r1_mask, r1_addr, r1_wdata, r1_gnt, r1_rvalid, r1_rdata: same as r0_* for requester 1.
- mem_request  output  1  memory access strobe.
- mem_we_re  output  1  memory write/read select.
- mem_load  output  1  high on a granted read.
- mem_mask  output  4  to memory mask.
- mem_address  output  ADDR_W  to memory address.
- mem_data_in  output  DATA_W  to memory write data.
- mem_valid  input  1  memory read-valid, one cycle after mem_load.
- mem_data_out  input  DATA_W  memory read data.

Behaviour:
- Grant logic
  - Combinational, same cycle. A request is accepted in the cycle its gnt is high.
  - Only one of r0_gnt and r1_gnt may be high in a cycle.
  - A lone request is always granted.
  - Simultaneous requests:
    - ARB_MODE=0: the winner is the requester indicated by the priority pointer prio.
    - ARB_MODE=1: requester 0 always wins.
- Priority pointer prio
  - 1-bit register, reset value 0 (requester 0 favoured).
  - In ARB_MODE=0, after any grant, prio <= the id of the non-granted requester.
  - prio holds when nothing is granted.
- Memory drive
  - mem_request = r0_gnt | r1_gnt.
  - mem_we_re, mem_mask, mem_address, mem_data_in are muxed from the winner.
  - When idle, all memory outputs are 0.
  - mem_load = granted & !we_re of the winner.
- Read tracking
  - rd_pend (reset 0) and rd_owner (reset 0) are registered on every clock: rd_pend <= mem_load, rd_owner <= winner id.
  - Back-to-back reads from either requester are allowed; the tracking is a pipeline register, not a blocking FSM.
- Response routing
  - rX_rvalid = mem_valid & rd_pend & (rd_owner == X).
  - rX_rdata = mem_data_out when rX_rvalid, else 0.
  - mem_valid without rd_pend is ignored (no rvalid asserted).
- Writes produce no response; the gnt cycle completes the write.
- Reset
  - All outputs read 0 while rst is low: gnt, rvalid, rdata, and every mem_* signal.
  - Reset asserted mid-read clears rd_pend, so the returning data is dropped.
  - After release, prio=0.
- Starvation bound: in ARB_MODE=0, a continuously requesting requester is granted within 2 cycles. In ARB_MODE=1, requester 1 can starve; this is documented and intended for debug use.

Decomposition:
- Package dmem_arb_pkg contains:
  - typedef enum logic {REQ_CORE=0, REQ_DBG=1} req_id_e.
  - typedef struct packed mem_req_t {we_re, mask, addr, wdata}.
  - Constants ARB_RR=0 and ARB_FIXED=1.
- One sub-module, rr_arb2: the 2-input grant logic plus the prio register. Inputs req[1:0] and mode; outputs gnt[1:0] and win_id.
- The top level holds the request mux, the read-tracking registers and response demux.

Test Plan:
- Reset behaviour: hold rst=0 with r0_req=1 -> all outputs 0. Release rst -> first cycle r0_gnt=1 and prio becomes 1.
- Single read: r0 reads addr 0x10, with the memory preloaded with 0xDEADBEEF -> gnt at cycle N with mem_load=1; r0_rvalid=1 and r0_rdata=0xDEADBEEF at N+1; r1_rvalid stays 0.
- Contention, ARB_MODE=0: both requesters hold requests (r0 writes 0xA5A5A5A5 to 0x04, r1 reads 0x08) for 4 cycles -> grants alternate r0, r1, r0, r1. The r1 read returns in the cycle after its grant, with rvalid only on r1.
- Fixed priority, ARB_MODE=1: both requesters hold requests for 5 cycles -> r0_gnt=1 every cycle and r1_gnt=0. r1 is granted in the first cycle r0_req drops.
- Back-to-back reads: r1 reads 0x01 then r0 reads 0x02 in consecutive cycles -> r1_rvalid at cycle N+1 and r0_rvalid at N+2, each with correct data.
- Reset mid-read: r0 read granted at N, rst pulsed low between N and N+1 -> no rvalid asserted and rd_pend=0. The next request after release is granted normally.
